crc16_serial_checker: RTL and testbench

CRC16_SERIAL_CHECKER -- requirements
Module: crc16_serial_checker

---
 rtl/crc16_serial_checker.sv | 105 ++++++++++
 tb/tb_crc16_serial_checker.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/crc16_serial_checker.sv
// rtl/crc16_serial_checker.sv - serial CRC-16 (poly 0x1021) frame checker.
// Define CRC16_CHK_DATA_CAPTURE_EN to build the payload capture register behind data_out.
module crc16_serial_checker #(
  parameter int          DATA_BITS = 32,
  parameter logic [15:0] CRC_INIT  = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 busy,
  output logic                 done,
  output logic                 crc_ok,
  output logic                 crc_err,
  output logic [15:0]          crc_calc,
  output logic [DATA_BITS-1:0] data_out
);

  localparam int CW = $clog2(DATA_BITS + 16 + 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_CRC  = CW'(DATA_BITS + 15);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [15:0]   lfsr, lfsr_nxt;
  logic          accept;
  logic          last_data, last_crc;

  // frame_start has priority: a coincident bit is never consumed
  assign accept    = bit_valid && !frame_start && (state == S_DATA || state == S_CRC);
  assign last_data = (bit_cnt == LAST_DATA);
  assign last_crc  = (bit_cnt == LAST_CRC);
  assign lfsr_nxt  = {lfsr[14:0], 1'b0} ^ ((lfsr[15] ^ bit_in) ? 16'h1021 : 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (frame_start) begin
      state_nxt = S_DATA;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_DATA:  if (accept && last_data) state_nxt = S_CRC;
        S_CRC:   if (accept && last_crc)  state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_DATA, S_CRC: busy = 1'b1;
      S_DONE:        done = 1'b1;
      default:       ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= CRC_INIT;
      bit_cnt  <= '0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      crc_calc <= 16'h0000;
    end else if (frame_start) begin
      lfsr    <= CRC_INIT;
      bit_cnt <= '0;
      crc_ok  <= 1'b0;
      crc_err <= 1'b0;
    end else if (accept) begin
      lfsr    <= lfsr_nxt;
      bit_cnt <= bit_cnt + CW'(1);
      if (state == S_DATA && last_data) crc_calc <= lfsr_nxt;
      if (state == S_CRC && last_crc) begin
        crc_ok  <= (lfsr_nxt == 16'h0000);
        crc_err <= (lfsr_nxt != 16'h0000);
      end
    end
  end

`ifdef CRC16_CHK_DATA_CAPTURE_EN
  logic [DATA_BITS-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           data_q <= '0;
    else if (frame_start)              data_q <= '0;
    else if (accept && state == S_DATA) data_q <= (data_q << 1) | DATA_BITS'(bit_in);
  end

  assign data_out = data_q;
`else
  assign data_out = '0;
`endif

endmodule

// File: tb/tb_crc16_serial_checker.sv
// tb/tb_crc16_serial_checker.sv - scoreboard bench for crc16_serial_checker.
module tb_crc16_serial_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, bit_valid, bit_in;
  logic        busy, done, crc_ok, crc_err;
  logic [15:0] crc_calc;
  logic [31:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic        ok;
    logic [15:0] calc;
    logic [31:0] data;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];

  crc16_serial_checker dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
    .bit_in(bit_in), .busy(busy), .done(done), .crc_ok(crc_ok), .crc_err(crc_err),
    .crc_calc(crc_calc), .data_out(data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference for payloads whose CRC is not worked out by hand
  function automatic logic [15:0] crc_model(input logic [31:0] d);
    logic [15:0] r = 16'h0000;
    for (int i = 31; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("crc_ok",     crc_ok,      e.ok);
        chk("crc_err",    crc_err,     !e.ok);
        chk("crc_calc",   crc_calc,    e.calc);
        chk("data_out",   data_out,    e.data);
        chk("done_cycle", 64'(cyc),    64'(e.done_cyc));
      end
    end
  end

  task automatic drive_frame(input logic [31:0] pl, input logic [15:0] cb, input bit toggle,
                             input int abort_at, input bit junk,
                             input logic exp_ok, input logic [15:0] exp_calc);
    logic [47:0] bits;
    exp_t e;
    bits = {pl, cb};
    frame_start = 1'b1;
    bit_valid   = junk;
    bit_in      = 1'b1;
    if (abort_at < 0) begin
      e.ok       = exp_ok;
      e.calc     = exp_calc;
`ifdef CRC16_CHK_DATA_CAPTURE_EN
      e.data     = pl;
`else
      e.data     = 32'h0;
`endif
      e.done_cyc = cyc + (toggle ? 97 : 49);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    for (int n = 0; n < 48; n++) begin
      if (n == abort_at) return;
      if (toggle) begin
        bit_valid = 1'b0;
        @(posedge clk); #1;
      end
      bit_valid = 1'b1;
      bit_in    = bits[47-n];
      @(posedge clk); #1;
    end
    bit_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] dbf_crc;
    rst = 1'b1; frame_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ok",   crc_ok, 0);
    chk("rst_err",  crc_err, 0);
    chk("rst_calc", crc_calc, 0);
    chk("rst_data", data_out, 0);
    rst = 1'b0;

    // bits offered while idle must not start anything
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    bit_valid = 1'b0;

    drive_frame(32'h00000001, 16'h1021, 1'b0, -1, 1'b1, 1'b1, 16'h1021);
    wait_drain();
    repeat (3) @(posedge clk); #1;
    chk("ok_held",   crc_ok, 1);
    chk("calc_held", crc_calc, 16'h1021);

    drive_frame(32'h00000001, 16'h1020, 1'b0, -1, 1'b0, 1'b0, 16'h1021);
    wait_drain();
    chk("err_held", crc_err, 1);

    drive_frame(32'h00000000, 16'h0000, 1'b1, -1, 1'b0, 1'b1, 16'h0000);
    wait_drain();

    drive_frame(32'hDEADBEEF, 16'h0000, 1'b0, 10, 1'b0, 1'b0, 16'h0000);
    drive_frame(32'h00000001, 16'h1021, 1'b0, -1, 1'b0, 1'b1, 16'h1021);
    wait_drain();

    drive_frame(32'hDEADBEEF, 16'h0000, 1'b0, 20, 1'b0, 1'b0, 16'h0000);
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ok",   crc_ok, 0);
    chk("midrst_err",  crc_err, 0);
    chk("midrst_calc", crc_calc, 0);
    chk("midrst_data", data_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_frame(32'h00000001, 16'h1021, 1'b0, -1, 1'b0, 1'b1, 16'h1021);
    wait_drain();

    dbf_crc = crc_model(32'hDEADBEEF);
    drive_frame(32'hDEADBEEF, dbf_crc, 1'b0, -1, 1'b0, 1'b1, dbf_crc);
    wait_drain();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
